// File: rtl/alu_ctrl_pkg.sv
// ALU control package: ALU codes, funct and alu_op encodings, FSM state
// type and a small helper used to size the latency counter.
package alu_ctrl_pkg;

  localparam int CODE_W = 4;
  typedef logic [CODE_W-1:0] code_t;

  // ALU control codes driven to the EX stage
  localparam code_t ALU_AND  = 4'b0000;
  localparam code_t ALU_OR   = 4'b0001;
  localparam code_t ALU_ADD  = 4'b0010;
  localparam code_t ALU_NOR  = 4'b0011;
  localparam code_t ALU_SUB  = 4'b0100;
  localparam code_t ALU_SLT  = 4'b0111;
  localparam code_t ALU_MULT = 4'b1000;
  localparam code_t ALU_DIV  = 4'b1001;
  localparam code_t ALU_SRL  = 4'b1010;
  localparam code_t ALU_SLL  = 4'b1100;

  // Main-decoder alu_op encodings
  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // R-type funct encodings
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  // Sequencer states: idle, multi-cycle op running, multi-cycle result ready
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALU control decoder. Every path assigns the code,
// so an undefined encoding can never leave an earlier code in place; such
// encodings fall back to ADD and raise is_illegal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output code_t      code,
  output logic       is_mc,
  output logic       is_illegal
);

  // Map alu_op/funct to an ALU code and classify it
  always_comb begin
    code       = ALU_ADD;
    is_mc      = 1'b0;
    is_illegal = 1'b0;
    case (alu_op)
      OP_MEM:    code = ALU_ADD;
      OP_BRANCH: code = ALU_SUB;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_NOR:  code = ALU_NOR;
          FN_SLT:  code = ALU_SLT;
          FN_SLL:  code = ALU_SLL;
          FN_SRL:  code = ALU_SRL;
          FN_MULT: begin
            code  = ALU_MULT;
            is_mc = 1'b1;
          end
          FN_DIV: begin
            code  = ALU_DIV;
            is_mc = 1'b1;
          end
          default: begin
            code       = ALU_ADD;
            is_illegal = 1'b1;
          end
        endcase
      end
      OP_RSVD: begin
        code       = ALU_ADD;
        is_illegal = 1'b1;
      end
      default: begin
        code       = ALU_ADD;
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer. Registers the decoded ALU control code with one
// cycle of latency and tracks MULT/DIV operations through an
// IDLE -> BUSY -> DONE state machine with a down-counter. Flush kills the
// current and in-flight operation; reset aborts everything asynchronously.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              stall_in,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              illegal
);

  // One extra bit over the largest latency so loads never overflow
  localparam int MAX_LAT = max_int(MUL_LAT, DIV_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t MUL_LOAD = cnt_t'(MUL_LAT - 1);
  localparam cnt_t DIV_LOAD = cnt_t'(DIV_LAT - 1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  state_t            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ill_q, ill_d;

  code_t dec_code;
  logic  dec_is_mc;
  logic  dec_illegal;
  logic  accept;

  alu_ctrl_decode u_decode (
    .alu_op     (alu_op),
    .funct      (funct),
    .code       (dec_code),
    .is_mc      (dec_is_mc),
    .is_illegal (dec_illegal)
  );

  // New requests are only taken when not held, not flushed, and no op is running
  assign in_ready = !stall_in && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept   = in_valid && in_ready;

  // Next-state and next-output logic; flush wins over everything else
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ill_d   = ill_q;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      ctrl_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ill_d   = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = CTRL_W'(dec_code);
      ill_d   = dec_illegal;
      if (dec_is_mc) begin
        state_d = ST_BUSY;
        cnt_d   = (dec_code == ALU_DIV) ? DIV_LOAD : MUL_LOAD;
        busy_d  = 1'b1;
        done_d  = 1'b0;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stall_in) begin
            valid_d = 1'b0;
            ill_d   = 1'b0;
          end
        end
        ST_BUSY: begin
          valid_d = 1'b0;
          ill_d   = 1'b0;
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          valid_d = 1'b0;
          ill_d   = 1'b0;
          if (!stall_in) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          ill_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_ctrl  = ctrl_q;
  assign mc_busy   = busy_q;
  assign mc_done   = done_q;
  assign illegal   = ill_q;

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter CTRL_W, default 4, width of the ALU control code (minimum 4).
REQ-002 Parameter MUL_LAT, default 4, cycles from MULT accept to mc_done (minimum 2).
REQ-003 Parameter DIV_LAT, default 16, cycles from DIV accept to mc_done (minimum 2).
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  in  1  decode request present on alu_op/funct.
REQ-007 Port alu_op  in  2  main-decoder ALU op (00 mem/addi, 01 branch, 10 R-type, 11 reserved).
REQ-008 Port funct  in  6  R-type function field.
REQ-009 Port stall_in  in  1  downstream hold request.
REQ-010 Port flush  in  1  pipeline flush, kills the current and in-flight operation.
REQ-011 Port in_ready  out  1  request accepted this cycle when in_valid & in_ready.
REQ-012 Port out_valid  out  1  alu_ctrl is valid for the EX stage.
REQ-013 Port alu_ctrl  out  CTRL_W  registered ALU control code.
REQ-014 Port mc_busy  out  1  multi-cycle MULT/DIV in progress.
REQ-015 Port mc_done  out  1  multi-cycle result ready.
REQ-016 Port illegal  out  1  registered flag: accepted request had an undefined encoding.

Function
REQ-017 Decode SHALL be: alu_op 00 -> 0010 (add); 01 -> 0100 (sub); 10 by funct: 100000 add 0010, 100010 sub 0100, 100100 and 0000, 100101 or 0001, 100111 nor 0011, 101010 slt 0111, 000000 sll 1100, 000010 srl 1010, 011000 mult 1000, 011010 div 1001; codes zero-extended to CTRL_W.
REQ-018 alu_op 11 or an unlisted funct SHALL yield alu_ctrl 0010 with illegal=1 for that output cycle; no decode path SHALL retain a stale code.
REQ-019 Latency SHALL be one cycle: a request accepted at edge T appears on out_valid/alu_ctrl/illegal after edge T.
REQ-020 in_ready SHALL equal !stall_in & !flush & (state is IDLE or DONE).
REQ-021 With no accept and no stall, out_valid SHALL drop to 0 next cycle; with stall_in=1 in IDLE, out_valid/alu_ctrl/illegal SHALL hold.
REQ-022 FSM states IDLE, BUSY, DONE; accept of MULT/DIV from IDLE or DONE -> BUSY with counter loaded to LAT-1 (MUL_LAT or DIV_LAT).
REQ-023 In BUSY the counter SHALL decrement every cycle regardless of stall_in; at counter 1 -> DONE.
REQ-024 For accept at edge T: out_valid=1 for cycle T+1 only, mc_busy=1 cycles T+1..T+LAT-1, mc_done=1 from cycle T+LAT, alu_ctrl held at the MULT/DIV code throughout.
REQ-025 DONE SHALL persist while stall_in=1; with stall_in=0, DONE -> IDLE, or -> BUSY on a new MULT/DIV accept, same edge.
REQ-026 flush SHALL have priority over stall_in and in_valid: next cycle state IDLE, out_valid 0, mc_busy 0, mc_done 0, illegal 0, counter 0.
REQ-027 Counter width SHALL be $clog2 of max(MUL_LAT, DIV_LAT) plus 1 bit; no wrap-around permitted.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, counter 0, out_valid 0, alu_ctrl 0, mc_busy 0, mc_done 0, illegal 0; in_ready follows REQ-020.
REQ-029 Reset asserted mid-BUSY SHALL abort the operation with no mc_done pulse after release.

Structure
REQ-030 Package alu_ctrl_pkg SHALL hold ALU code constants, funct constants, alu_op constants and the FSM state type.
REQ-031 Combinational decode SHALL live in sub-module alu_ctrl_decode (alu_op, funct -> code, is_mc, is_illegal); alu_ctrl_seq holds all registers.

Verification
REQ-032 alu_op=10, funct=100010, in_valid 1 cycle -> next cycle out_valid=1, alu_ctrl=0100, illegal=0; following cycle out_valid=0.
REQ-033 MULT (funct 011000), MUL_LAT=4, accept at T -> out_valid only T+1, mc_busy T+1..T+3, in_ready=0 T+1..T+3, mc_done=1 at T+4, alu_ctrl=1000.
REQ-034 DIV with DIV_LAT=16, stall_in=1 from T+5 to T+20 -> mc_done=1 at T+16, held through T+20, IDLE at T+21.
REQ-035 alu_op=11 and alu_op=10/funct=111111 -> alu_ctrl=0010, illegal=1 each.
REQ-036 flush at T+2 of a MULT -> T+3 mc_busy=0, mc_done never asserts, in_ready=1.
REQ-037 rst_n low mid-DIV for 1 cycle -> all outputs 0 immediately, no later mc_done; next ADD request decodes to 0010.
